keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive identical row samples (range 2..255) required to accept a press or a release.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port row, input, 4 bits: keypad row sense lines, active-high, where bit i is row i.
REQ-005 The block SHALL have port col, output, 3 bits: one-hot column drive, registered.
REQ-006 The block SHALL have port key, output, 4 bits: decoded key code for the digit shift register, registered.
REQ-007 The block SHALL have port shift, output, 1 bit: a one-cycle strobe telling the digit shift register to shift in key, registered.

Function
REQ-008 Key map, row/col to code: r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = STAR(11), 0, HASH(12).
REQ-009 key SHALL equal NOKEY (4'd10) whenever no key is accepted.
REQ-010 The FSM SHALL have the states SCAN, DEBOUNCE, EMIT, HOLD and RELEASE.
REQ-011 In SCAN, col SHALL rotate every clock in the order 001 -> 010 -> 100 -> 001.
REQ-012 In SCAN, a sample with exactly one row bit set SHALL latch row and col, freeze col, set cnt=1 and enter DEBOUNCE.
REQ-013 In SCAN, a sample with zero row bits set, or with more than one, SHALL keep the block scanning.
REQ-014 In DEBOUNCE, each sample equal to the latched row SHALL increment cnt.
REQ-015 In DEBOUNCE, when a matching sample brings cnt to DEBOUNCE_CYCLES, the FSM SHALL enter EMIT.
REQ-016 In DEBOUNCE, any mismatching sample, including zero or multiple rows, SHALL return the FSM to SCAN with col resuming rotation from the next column and key=NOKEY.
REQ-017 In EMIT, which lasts exactly one cycle, key SHALL equal the decoded code, and shift SHALL be 1 only if that code is 0..9; STAR and HASH produce no shift.
REQ-018 With the default parameter, shift SHALL be high in the cycle following the 4th consecutive stable sample, where the detection sample counts as the 1st.
REQ-019 In HOLD, key SHALL hold the code and shift SHALL be 0; a sample with row==0 SHALL enter RELEASE with cnt=1.
REQ-020 A held key SHALL never produce a second shift, however long it is held.
REQ-021 In RELEASE, each sample with row==0 SHALL increment cnt.
REQ-022 In RELEASE, when cnt reaches DEBOUNCE_CYCLES the FSM SHALL go to SCAN with key=NOKEY, and the next press SHALL be able to emit again.
REQ-023 In RELEASE, a nonzero sample SHALL return the FSM to HOLD with no new shift.
REQ-024 shift SHALL never be high for two consecutive cycles.
REQ-025 Sampling rule: the row sample taken on a clock edge SHALL correspond to the col value driven during the preceding cycle.
REQ-026 cnt SHALL be 8 bits wide and SHALL saturate rather than wrap.

Reset
REQ-027 Asserting reset at any time SHALL immediately force state=SCAN, col=3'b001, key=NOKEY, shift=0 and cnt=0.
REQ-028 A reset asserted during DEBOUNCE, EMIT, HOLD or RELEASE SHALL discard the pending key, and no shift SHALL follow the release of reset unless a new press is fully debounced.

Structure
REQ-029 NOKEY, STAR, HASH and the FSM state encoding SHALL live in the shared alarm clock package, so that the digit shift register and other blocks use the same codes.
REQ-030 The row/col-to-code mapping SHALL be the combinational sub-module keypad_decode, taking the one-hot row and col and returning a 4-bit code.

Verification
REQ-031 The bench SHALL hold row=0010 while col=010 for 6 cycles and check key=5 with shift high for exactly one cycle, 4 cycles after detection.
REQ-032 The bench SHALL make row bounce 0010,0000,0010 within the debounce window and check no shift, key=NOKEY and col rotation resuming.
REQ-033 The bench SHALL hold key 8 for 200 cycles and check exactly one shift, key=8 throughout HOLD, and key=NOKEY 4 cycles after release.
REQ-034 The bench SHALL drive row=0011 on col 001, a two-row press, and check no DEBOUNCE entry and no shift.
REQ-035 The bench SHALL press the STAR position (row3, col001) and check key=11 with shift=0.
REQ-036 The bench SHALL press 1,2,3,4 in sequence and check each emits one shift, and that the digit shift register ends with ms_hr=1, ls_hr=2, ms_min=3, ls_min=4; it SHALL also assert reset mid-HOLD and check the outputs return to reset values with no shift.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Key codes and scanner state encoding shared by the keypad scanner, the digit
// shift register and the other alarm clock blocks.
package keypad_scanner_pkg;

  localparam logic [3:0] NOKEY = 4'd10;
  localparam logic [3:0] STAR  = 4'd11;
  localparam logic [3:0] HASH  = 4'd12;

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    EMIT     = 3'd2,
    HOLD     = 3'd3,
    RELEASE  = 3'd4
  } scan_state_t;

  function automatic logic [2:0] rotate_col(input logic [2:0] c);
    return {c[1:0], c[2]};
  endfunction

  function automatic logic is_one_hot4(input logic [3:0] r);
    return (r != 4'd0) && ((r & (r - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational map from one-hot row/col position to the keypad code;
// anything that is not a single valid position decodes to NOKEY.
module keypad_decode
  import keypad_scanner_pkg::*;
(
  input  logic [3:0] row,
  input  logic [2:0] col,
  output logic [3:0] code
);

  always_comb begin
    code = NOKEY;
    case (row)
      4'b0001:
        case (col)
          3'b001:  code = 4'd1;
          3'b010:  code = 4'd2;
          3'b100:  code = 4'd3;
          default: code = NOKEY;
        endcase
      4'b0010:
        case (col)
          3'b001:  code = 4'd4;
          3'b010:  code = 4'd5;
          3'b100:  code = 4'd6;
          default: code = NOKEY;
        endcase
      4'b0100:
        case (col)
          3'b001:  code = 4'd7;
          3'b010:  code = 4'd8;
          3'b100:  code = 4'd9;
          default: code = NOKEY;
        endcase
      4'b1000:
        case (col)
          3'b001:  code = STAR;
          3'b010:  code = 4'd0;
          3'b100:  code = HASH;
          default: code = NOKEY;
        endcase
      default: code = NOKEY;
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
// 3x4 keypad scanner: rotates the column drive, debounces a single-row press,
// emits one shift strobe per accepted digit and debounces the release.
//
// state    | meaning
// SCAN     | rotating col each clock, waiting for exactly one row bit
// DEBOUNCE | col frozen, counting samples equal to the latched row
// EMIT     | one cycle: key = decoded code, shift for digits 0..9
// HOLD     | key held, waiting for row == 0
// RELEASE  | counting row == 0 samples before returning to SCAN
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key,
  output logic       shift
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  scan_state_t state, state_nxt;
  logic [2:0]  col_nxt;
  logic [3:0]  key_nxt;
  logic        shift_nxt;
  logic [7:0]  cnt, cnt_nxt, cnt_inc;
  logic [3:0]  row_lat, row_lat_nxt;
  logic [3:0]  code;

  // The frozen col register doubles as the latched column during a press.
  keypad_decode u_decode (
    .row  (row_lat),
    .col  (col),
    .code (code)
  );

  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= SCAN;
      col     <= 3'b001;
      key     <= NOKEY;
      shift   <= 1'b0;
      cnt     <= 8'd0;
      row_lat <= 4'd0;
    end else begin
      state   <= state_nxt;
      col     <= col_nxt;
      key     <= key_nxt;
      shift   <= shift_nxt;
      cnt     <= cnt_nxt;
      row_lat <= row_lat_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    key_nxt     = key;
    shift_nxt   = 1'b0;
    cnt_nxt     = cnt;
    row_lat_nxt = row_lat;
    case (state)
      SCAN: begin
        key_nxt = NOKEY;
        if (is_one_hot4(row)) begin
          row_lat_nxt = row;
          cnt_nxt     = 8'd1;
          state_nxt   = DEBOUNCE;
        end else begin
          col_nxt = rotate_col(col);
          cnt_nxt = 8'd0;
        end
      end
      DEBOUNCE: begin
        if (row == row_lat) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= DB_LIMIT) begin
            state_nxt = EMIT;
            key_nxt   = code;
            shift_nxt = (code <= 4'd9);
            cnt_nxt   = 8'd0;
          end
        end else begin
          state_nxt = SCAN;
          col_nxt   = rotate_col(col);
          key_nxt   = NOKEY;
          cnt_nxt   = 8'd0;
        end
      end
      EMIT: begin
        state_nxt = HOLD;
        cnt_nxt   = 8'd0;
      end
      HOLD: begin
        if (row == 4'd0) begin
          state_nxt = RELEASE;
          cnt_nxt   = 8'd1;
        end
      end
      RELEASE: begin
        if (row == 4'd0) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= DB_LIMIT) begin
            state_nxt = SCAN;
            key_nxt   = NOKEY;
            col_nxt   = rotate_col(col);
            cnt_nxt   = 8'd0;
          end
        end else begin
          state_nxt = HOLD;
          cnt_nxt   = 8'd0;
        end
      end
      default: begin
        state_nxt = SCAN;
        col_nxt   = 3'b001;
        key_nxt   = NOKEY;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model answers the column
// drive, and accepted digits are checked against a queue of expected codes.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] key;
  logic       shift;

  logic [2:0] kp_col  = 3'b001;
  logic [3:0] kp_rows = 4'd0;

  int         errors = 0;
  int         checks = 0;
  int         shift_count = 0;
  logic       prev_shift = 1'b0;
  logic [3:0] sb[$];
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;

  always #5 clock = ~clock;

  // Pressed keys only reach the row lines while their column is driven.
  assign row = (col == kp_col) ? kp_rows : 4'd0;

  keypad_scanner dut (
    .clock (clock),
    .reset (reset),
    .row   (row),
    .col   (col),
    .key   (key),
    .shift (shift)
  );

  // One cycle; every shift strobe is checked against the scoreboard and
  // clocks the downstream digit register model.
  task automatic step();
    logic [3:0] exp;
    @(negedge clock);
    if (shift) begin
      shift_count++;
      checks++;
      if (prev_shift) begin
        errors++;
        $display("FAIL shift_consecutive: shift=1 in two consecutive cycles");
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: shift with key=%0d, no key expected", key);
      end else begin
        exp = sb.pop_front();
        if (key !== exp) begin
          errors++;
          $display("FAIL sb_key: key=%0d expected=%0d", key, exp);
        end
      end
      ms_hr  = ls_hr;
      ls_hr  = ms_min;
      ms_min = ls_min;
      ls_min = key;
    end
    prev_shift = shift;
  endtask

  task automatic wait_col(input logic [2:0] c);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (col === c) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_col: col=%b never reached %b", col, c);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    kp_rows = 4'd0;
    reset = 1'b1;
    #1;
    checks++;
    if (col !== 3'b001) begin errors++; $display("FAIL reset_col: col=%b expected=001", col); end
    checks++;
    if (key !== NOKEY) begin errors++; $display("FAIL reset_key: key=%0d expected=10", key); end
    checks++;
    if (shift !== 1'b0) begin errors++; $display("FAIL reset_shift: shift=%b expected=0", shift); end
    apply_reset();
  endtask

  task automatic test_press_5();
    int base;
    kp_col = 3'b010;
    kp_rows = 4'b0010;
    apply_reset();
    sb.push_back(4'd5);
    base = shift_count;
    step();
    checks++;
    if (col !== 3'b010) begin errors++; $display("FAIL p5_rotate: col=%b expected=010", col); end
    step();
    checks++;
    if (col !== 3'b010 || key !== NOKEY || shift !== 1'b0) begin
      errors++;
      $display("FAIL p5_detect: col=%b key=%0d shift=%b expected col=010 key=10 shift=0", col, key, shift);
    end
    step();
    step();
    checks++;
    if (shift !== 1'b0) begin errors++; $display("FAIL p5_early: shift=%b expected=0", shift); end
    step();
    checks++;
    if (shift !== 1'b1 || key !== 4'd5) begin
      errors++;
      $display("FAIL p5_emit: shift=%b key=%0d expected shift=1 key=5", shift, key);
    end
    step();
    checks++;
    if (shift !== 1'b0 || key !== 4'd5) begin
      errors++;
      $display("FAIL p5_hold: shift=%b key=%0d expected shift=0 key=5", shift, key);
    end
    kp_rows = 4'd0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (key !== NOKEY) begin errors++; $display("FAIL p5_release: key=%0d expected=10", key); end
    checks++;
    if (shift_count - base !== 1) begin
      errors++;
      $display("FAIL p5_count: shifts=%0d expected=1", shift_count - base);
    end
  endtask

  task automatic test_bounce();
    int base;
    kp_rows = 4'd0;
    step();
    wait_col(3'b010);
    kp_col = 3'b010;
    kp_rows = 4'b0010;
    base = shift_count;
    step();
    checks++;
    if (col !== 3'b010) begin errors++; $display("FAIL bounce_freeze: col=%b expected=010", col); end
    kp_rows = 4'd0;
    step();
    checks++;
    if (col !== 3'b100 || key !== NOKEY) begin
      errors++;
      $display("FAIL bounce_resume: col=%b key=%0d expected col=100 key=10", col, key);
    end
    kp_rows = 4'b0010;
    step();
    checks++;
    if (col !== 3'b001) begin errors++; $display("FAIL bounce_rotate: col=%b expected=001", col); end
    kp_rows = 4'd0;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (shift_count != base || key !== NOKEY) begin
      errors++;
      $display("FAIL bounce_noshift: shifts=%0d key=%0d expected 0 and 10", shift_count - base, key);
    end
  endtask

  task automatic test_hold_8();
    int base;
    int bad;
    bit seen;
    kp_col = 3'b010;
    kp_rows = 4'b0100;
    sb.push_back(4'd8);
    base = shift_count;
    bad = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (shift) seen = 1'b1;
      else if (seen && key !== 4'd8) bad++;
    end
    checks++;
    if (!seen || bad != 0) begin
      errors++;
      $display("FAIL hold8_key: emitted=%0d bad_cycles=%0d expected 1 and 0", seen, bad);
    end
    checks++;
    if (shift_count - base !== 1) begin
      errors++;
      $display("FAIL hold8_count: shifts=%0d expected=1", shift_count - base);
    end
    kp_rows = 4'd0;
    step();
    step();
    step();
    checks++;
    if (key !== 4'd8) begin errors++; $display("FAIL hold8_early_release: key=%0d expected=8", key); end
    step();
    checks++;
    if (key !== NOKEY) begin errors++; $display("FAIL hold8_release: key=%0d expected=10", key); end
  endtask

  task automatic test_two_row();
    int base;
    int frozen;
    logic [2:0] prev_col;
    kp_rows = 4'd0;
    wait_col(3'b001);
    kp_col = 3'b001;
    kp_rows = 4'b0011;
    base = shift_count;
    frozen = 0;
    prev_col = col;
    for (int i = 0; i < 12; i++) begin
      step();
      if (col === prev_col || key !== NOKEY) frozen++;
      prev_col = col;
    end
    checks++;
    if (frozen != 0) begin
      errors++;
      $display("FAIL two_row_scan: stalled_cycles=%0d expected=0", frozen);
    end
    checks++;
    if (shift_count != base) begin
      errors++;
      $display("FAIL two_row_shift: shifts=%0d expected=0", shift_count - base);
    end
    kp_rows = 4'd0;
  endtask

  task automatic test_star();
    int base;
    bit seen;
    kp_col = 3'b001;
    kp_rows = 4'b1000;
    base = shift_count;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (key === STAR) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL star_key: key=%0d, 11 never seen", key); end
    checks++;
    if (shift_count != base) begin
      errors++;
      $display("FAIL star_shift: shifts=%0d expected=0", shift_count - base);
    end
    kp_rows = 4'd0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (key !== NOKEY) begin errors++; $display("FAIL star_release: key=%0d expected=10", key); end
  endtask

  task automatic press_key(input logic [2:0] c, input logic [3:0] r, input logic [3:0] code);
    int base;
    sb.push_back(code);
    base = shift_count;
    kp_col = c;
    kp_rows = r;
    for (int i = 0; i < 12; i++) step();
    kp_rows = 4'd0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (shift_count - base !== 1 || key !== NOKEY) begin
      errors++;
      $display("FAIL press_%0d: shifts=%0d key=%0d expected 1 and 10", code, shift_count - base, key);
    end
  endtask

  task automatic test_sequence();
    ms_hr = 4'hF;
    ls_hr = 4'hF;
    ms_min = 4'hF;
    ls_min = 4'hF;
    press_key(3'b001, 4'b0001, 4'd1);
    press_key(3'b010, 4'b0001, 4'd2);
    press_key(3'b100, 4'b0001, 4'd3);
    press_key(3'b001, 4'b0010, 4'd4);
    checks++;
    if (ms_hr !== 4'd1) begin errors++; $display("FAIL seq_ms_hr: got=%0d expected=1", ms_hr); end
    checks++;
    if (ls_hr !== 4'd2) begin errors++; $display("FAIL seq_ls_hr: got=%0d expected=2", ls_hr); end
    checks++;
    if (ms_min !== 4'd3) begin errors++; $display("FAIL seq_ms_min: got=%0d expected=3", ms_min); end
    checks++;
    if (ls_min !== 4'd4) begin errors++; $display("FAIL seq_ls_min: got=%0d expected=4", ls_min); end
  endtask

  task automatic test_reset_in_hold();
    int base;
    kp_col = 3'b001;
    kp_rows = 4'b0100;
    sb.push_back(4'd7);
    base = shift_count;
    for (int i = 0; i < 20 && shift_count == base; i++) step();
    checks++;
    if (shift_count == base) begin errors++; $display("FAIL rst_hold_emit: no shift for key 7"); end
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (col !== 3'b001 || key !== NOKEY || shift !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold_values: col=%b key=%0d shift=%b expected 001 10 0", col, key, shift);
    end
    kp_rows = 4'd0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (shift_count - base !== 1 || key !== NOKEY) begin
      errors++;
      $display("FAIL rst_hold_after: shifts=%0d key=%0d expected 1 and 10", shift_count - base, key);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_press_5();
    test_bounce();
    test_hold_8();
    test_two_row();
    test_star();
    test_sequence();
    test_reset_in_hold();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected keys never emitted", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
